// File: rtl/de0_dbg_pkg.sv
// Shared types, default widths and helpers for the debug-slave sysclk command queue.
package de0_dbg_pkg;

    typedef enum logic [1:0] {
        IR_OCIMEM    = 2'd0,
        IR_TRACEMEM  = 2'd1,
        IR_BREAK     = 2'd2,
        IR_TRACECTRL = 2'd3
    } ir_e;

    localparam int unsigned IR_W_DEF = 2;
    localparam int unsigned SR_W_DEF = 38;
    localparam int unsigned ENTRY_W  = IR_W_DEF + SR_W_DEF;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/de0_debug_slave_sysclk_cmdq_if.sv
// JTAG-side capture inputs and core-side command outputs of the debug-slave sysclk bridge.
interface de0_debug_slave_sysclk_cmdq_if #(
    parameter int unsigned IR_W   = 2,
    parameter int unsigned SR_W   = 38,
    parameter int unsigned NUM_CH = 4
);
    logic [IR_W-1:0]   ir_in;
    logic [SR_W-1:0]   sr;
    logic              vs_uir;
    logic              vs_udr;
    logic              cmd_ready;
    logic              ovf_clr;
    logic              cmd_valid;
    logic [SR_W-1:0]   jdo;
    logic [NUM_CH-1:0] take_action;
    logic [NUM_CH-1:0] take_no_action;
    logic              cmd_bad;
    logic              ovf;

    modport master (
        output ir_in, sr, vs_uir, vs_udr, cmd_ready, ovf_clr,
        input  cmd_valid, jdo, take_action, take_no_action, cmd_bad, ovf
    );

    modport slave (
        input  ir_in, sr, vs_uir, vs_udr, cmd_ready, ovf_clr,
        output cmd_valid, jdo, take_action, take_no_action, cmd_bad, ovf
    );
endinterface

// File: rtl/de0_dbg_sync_edge.sv
// Two-flop synchroniser with rising-edge pulse; an input already high at reset release
// must fall before any edge is reported.
module de0_dbg_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);
    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic       armed_q;
    logic [1:0] settle_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            prev_q   <= 1'b0;
            armed_q  <= 1'b0;
            settle_q <= 2'b00;
        end else begin
            meta_q   <= d;
            sync_q   <= meta_q;
            prev_q   <= sync_q;
            settle_q <= {settle_q[0], 1'b1};
            // Arm only once sync_q reflects a genuinely sampled low level.
            if (settle_q[1] && !sync_q) armed_q <= 1'b1;
        end
    end

    assign pulse = armed_q & sync_q & ~prev_q;
endmodule

// File: rtl/de0_debug_slave_sysclk_cmdq.sv
// Brings JTAG UIR/UDR events into clk, queues {IR, sr} commands and decodes each popped
// command into per-channel take_action / take_no_action strobes.
module de0_debug_slave_sysclk_cmdq
    import de0_dbg_pkg::*;
#(
    parameter int unsigned IR_W       = IR_W_DEF,
    parameter int unsigned SR_W       = SR_W_DEF,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned ACT_BIT    = 37,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                          clk,
    input logic                          reset,
    de0_debug_slave_sysclk_cmdq_if.slave bus
);
    localparam int unsigned ADDR_W  = clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W   = ADDR_W + 1;
    localparam int unsigned ENTRY_WIDTH = IR_W + SR_W;

    logic                   uir_evt;
    logic                   udr_evt;
    logic [IR_W-1:0]        ir_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [ENTRY_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                   empty;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic [ENTRY_WIDTH-1:0] rd_entry;
    logic [IR_W-1:0]        pop_ir;
    logic [SR_W-1:0]        pop_sr;
    logic [NUM_CH-1:0]      take_action_d;
    logic [NUM_CH-1:0]      take_no_action_d;
    logic                   cmd_bad_d;

    de0_dbg_sync_edge u_sync_uir (
        .clk   (clk),
        .rst   (reset),
        .d     (bus.vs_uir),
        .pulse (uir_evt)
    );

    de0_dbg_sync_edge u_sync_udr (
        .clk   (clk),
        .rst   (reset),
        .d     (bus.vs_udr),
        .pulse (udr_evt)
    );

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign pop   = !empty && bus.cmd_ready;
    // A full queue still accepts a push when a pop frees a slot in the same cycle.
    assign push  = udr_evt && (!full || pop);
    assign drop  = udr_evt && full && !pop;

    assign rd_entry = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign pop_ir   = rd_entry[ENTRY_WIDTH-1 -: IR_W];
    assign pop_sr   = rd_entry[SR_W-1:0];

    assign bus.cmd_valid = !empty;

    always_comb begin
        take_action_d    = '0;
        take_no_action_d = '0;
        cmd_bad_d        = pop && (32'(pop_ir) >= NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            if (pop && (pop_ir == IR_W'(i))) begin
                take_action_d[i]    = pop_sr[ACT_BIT];
                take_no_action_d[i] = !pop_sr[ACT_BIT];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {ir_q, bus.sr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q               <= '0;
            wr_ptr_q           <= '0;
            rd_ptr_q           <= '0;
            bus.jdo            <= '0;
            bus.take_action    <= '0;
            bus.take_no_action <= '0;
            bus.cmd_bad        <= 1'b0;
            bus.ovf            <= 1'b0;
        end else begin
            if (uir_evt) ir_q <= bus.ir_in;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                bus.jdo  <= pop_sr;
            end
            bus.take_action    <= take_action_d;
            bus.take_no_action <= take_no_action_d;
            bus.cmd_bad        <= cmd_bad_d;
            if (drop) begin
                bus.ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                bus.ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_de0_debug_slave_sysclk_cmdq.sv
// Directed bench: a 4-channel and a 3-channel instance share stimulus; a scoreboard of
// queued {IR, sr} commands is checked against every strobe.
module tb_de0_debug_slave_sysclk_cmdq;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    de0_debug_slave_sysclk_cmdq_if #(.IR_W(2), .SR_W(38), .NUM_CH(4)) d1 ();
    de0_debug_slave_sysclk_cmdq_if #(.IR_W(2), .SR_W(38), .NUM_CH(3)) d2 ();

    assign d2.ir_in     = d1.ir_in;
    assign d2.sr        = d1.sr;
    assign d2.vs_uir    = d1.vs_uir;
    assign d2.vs_udr    = d1.vs_udr;
    assign d2.cmd_ready = d1.cmd_ready;
    assign d2.ovf_clr   = d1.ovf_clr;

    de0_debug_slave_sysclk_cmdq #(.NUM_CH(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (d1)
    );

    de0_debug_slave_sysclk_cmdq #(.NUM_CH(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (d2)
    );

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] sr;
    } exp_t;

    exp_t        sb[$];
    int          checks  = 0;
    int          errors  = 0;
    int          strobes = 0;
    int          bad_cnt = 0;
    int          s0;
    logic [1:0]  model_ir;
    logic [37:0] sr_v;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t       e;
        logic       act;
        logic       bad3;
        logic [3:0] ta4;
        logic [3:0] tna4;
        logic [2:0] ta3;
        logic [2:0] tna3;
        if (!reset && (|d1.take_action || |d1.take_no_action || d1.cmd_bad ||
                       |d2.take_action || |d2.take_no_action || d2.cmd_bad)) begin
            strobes++;
            if (d2.cmd_bad) bad_cnt++;
            chk("strobe_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e    = sb.pop_front();
                act  = e.sr[37];
                bad3 = (e.ir >= 2'd3);
                ta4  = act ? (4'b0001 << e.ir) : 4'b0000;
                tna4 = act ? 4'b0000 : (4'b0001 << e.ir);
                ta3  = (!bad3 && act) ? (3'b001 << e.ir) : 3'b000;
                tna3 = (!bad3 && !act) ? (3'b001 << e.ir) : 3'b000;
                chk("ta4", 64'(d1.take_action), 64'(ta4));
                chk("tna4", 64'(d1.take_no_action), 64'(tna4));
                chk("bad4", 64'(d1.cmd_bad), 64'd0);
                chk("jdo4", 64'(d1.jdo), 64'(e.sr));
                chk("ta3", 64'(d2.take_action), 64'(ta3));
                chk("tna3", 64'(d2.take_no_action), 64'(tna3));
                chk("bad3", 64'(d2.cmd_bad), 64'(bad3));
                chk("jdo3", 64'(d2.jdo), 64'(e.sr));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic uir(input logic [1:0] ir);
        d1.ir_in  = ir;
        d1.vs_uir = 1'b1;
        tick(2);
        d1.vs_uir = 1'b0;
        tick(2);
        model_ir = ir;
    endtask

    task automatic udr(input logic [37:0] s, input bit accept);
        d1.sr = s;
        if (accept) sb.push_back('{ir: model_ir, sr: s});
        d1.vs_udr = 1'b1;
        tick(2);
        d1.vs_udr = 1'b0;
        tick(2);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        tick(2);
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        reset        = 1'b1;
        d1.ir_in     = '0;
        d1.sr        = '0;
        d1.vs_uir    = 1'b0;
        d1.vs_udr    = 1'b0;
        d1.cmd_ready = 1'b0;
        d1.ovf_clr   = 1'b0;
        model_ir     = 2'd0;
        tick(3);
        chk("rst_cmd_valid", 64'(d1.cmd_valid), 64'd0);
        chk("rst_ovf", 64'(d1.ovf), 64'd0);
        chk("rst_jdo", 64'(d1.jdo), 64'd0);
        chk("rst_ta", 64'(d1.take_action), 64'd0);
        reset = 1'b0;
        tick(4);

        // Single command with exact latency.
        d1.cmd_ready = 1'b1;
        uir(2'd2);
        s0   = strobes;
        sr_v = {1'b1, 5'd0, 32'hDEADBEEF};
        d1.sr = sr_v;
        sb.push_back('{ir: model_ir, sr: sr_v});
        d1.vs_udr = 1'b1;
        tick(2);
        d1.vs_udr = 1'b0;
        tick(1);
        chk("t1_valid_c3", 64'(d1.cmd_valid), 64'd1);
        chk("t1_ta_c3", 64'(d1.take_action), 64'd0);
        tick(1);
        chk("t1_ta_c4", 64'(d1.take_action), 64'b0100);
        chk("t1_jdo_c4", 64'(d1.jdo[31:0]), 64'hDEADBEEF);
        tick(1);
        chk("t1_ta_c5", 64'(d1.take_action), 64'd0);
        chk("t1_valid_c5", 64'(d1.cmd_valid), 64'd0);
        chk("t1_strobes", 64'(strobes - s0), 64'd1);

        // Stall, then release four queued commands back to back.
        d1.cmd_ready = 1'b0;
        s0 = strobes;
        for (int k = 1; k <= 4; k++) udr(38'(k), 1'b1);
        tick(3);
        chk("t2_valid", 64'(d1.cmd_valid), 64'd1);
        chk("t2_no_strobes", 64'(strobes), 64'(s0));
        d1.cmd_ready = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            chk("t2_consec", 64'(d1.take_no_action), 64'b0100);
            chk("t2_jdo", 64'(d1.jdo), 64'(i + 1));
            tick(1);
        end
        chk("t2_tna_end", 64'(d1.take_no_action), 64'd0);
        chk("t2_valid_end", 64'(d1.cmd_valid), 64'd0);

        // Overflow, clear, then full + push + pop in the same cycle.
        d1.cmd_ready = 1'b0;
        for (int k = 11; k <= 14; k++) udr(38'(k), 1'b1);
        udr(38'd15, 1'b0);
        chk("t3_ovf_set", 64'(d1.ovf), 64'd1);
        chk("t3_valid", 64'(d1.cmd_valid), 64'd1);
        chk("t3_jdo_hold", 64'(d1.jdo), 64'd4);
        d1.ovf_clr = 1'b1;
        tick(1);
        d1.ovf_clr = 1'b0;
        chk("t3_ovf_clr", 64'(d1.ovf), 64'd0);
        sr_v  = 38'd16;
        d1.sr = sr_v;
        sb.push_back('{ir: model_ir, sr: sr_v});
        d1.vs_udr = 1'b1;
        tick(2);
        d1.cmd_ready = 1'b1;
        d1.vs_udr    = 1'b0;
        tick(1);
        chk("t3_no_ovf", 64'(d1.ovf), 64'd0);
        drain("t3_drain");

        // IR beyond the 3-channel instance's range.
        uir(2'd3);
        udr(38'h20_1234_5678, 1'b1);
        drain("t4_drain");
        chk("t4_bad_cnt", 64'(bad_cnt), 64'd1);

        // Coincident UIR/UDR: the entry carries the previous IR.
        uir(2'd1);
        d1.ir_in = 2'd3;
        sr_v     = 38'h0AA;
        d1.sr    = sr_v;
        sb.push_back('{ir: model_ir, sr: sr_v});
        d1.vs_uir = 1'b1;
        d1.vs_udr = 1'b1;
        tick(2);
        d1.vs_uir = 1'b0;
        d1.vs_udr = 1'b0;
        tick(2);
        model_ir = 2'd3;
        udr(38'h0BB, 1'b1);
        drain("t6_drain");

        // vs_udr held high across reset release.
        d1.vs_udr = 1'b1;
        reset     = 1'b1;
        tick(2);
        reset    = 1'b0;
        model_ir = 2'd0;
        s0       = strobes;
        tick(6);
        chk("t5_no_push", 64'(d1.cmd_valid), 64'd0);
        chk("t5_no_strobe", 64'(strobes), 64'(s0));
        d1.vs_udr = 1'b0;
        tick(3);
        udr(38'h3C, 1'b1);
        drain("t5_drain");
        chk("t5_one_push", 64'(strobes - s0), 64'd1);

        // Reset with a full queue and ovf set.
        d1.cmd_ready = 1'b0;
        for (int k = 1; k <= 4; k++) udr(38'(k), 1'b0);
        udr(38'd5, 1'b0);
        chk("t5_ovf_pre", 64'(d1.ovf), 64'd1);
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(d1.cmd_valid), 64'd0);
        chk("t5_rst_ovf", 64'(d1.ovf), 64'd0);
        tick(2);
        reset = 1'b0;
        tick(4);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
